// File: rtl/ball_game_ctrl.sv
// Per-frame ball sequencer: pitch-to-position rate limiting, gap collision, lives and score.
// Optional build macro SCORE_BCD_EN selects a packed-BCD score (0..99) instead of binary (0..255).
module ball_game_ctrl #(
  parameter int unsigned CENTER_POS    = 256,
  parameter int unsigned STEP_MAX      = 8,
  parameter int unsigned GAP_SLACK     = 96,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned FREEZE_FRAMES = 60
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        frame_in,
  input  logic        freq_valid_in,
  input  logic [15:0] freq_in,
  input  logic [8:0]  gap_pos_in,
  input  logic        pipe_at_ball_in,
  output logic [8:0]  ball_pos_out,
  output logic [1:0]  state_out,
  output logic [7:0]  score_out,
  output logic [1:0]  lives_out,
  output logic        hit_out
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PLAYING   = 2'd1;
  localparam logic [1:0] HIT       = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  localparam logic [8:0]        CENTER   = 9'(CENTER_POS);
  localparam logic [8:0]        STEP     = 9'(STEP_MAX);
  localparam logic signed [9:0] STEP_S   = 10'(STEP_MAX);
  localparam logic [9:0]        SLACK    = 10'(GAP_SLACK);
  localparam logic [1:0]        LIVES0   = 2'(LIVES_INIT);
  localparam logic [7:0]        FREEZE0  = 8'(FREEZE_FRAMES);

  logic [1:0] state;
  logic [8:0] ball_pos;
  logic [8:0] target;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit;
  logic [7:0] freeze_cnt;
  logic       pass_flag;

  logic signed [9:0] diff;
  logic [8:0]        next_pos;
  logic [9:0]        gap_hi;
  logic              collide;
  logic              unused_freq_bits;

  assign unused_freq_bits = ^{freq_in[15:11], freq_in[1:0]};

  function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
`else
    if (s == 8'hFF)
      return s;
    else
      return s + 8'd1;
`endif
  endfunction

  // Rate-limited step toward the target; |diff| <= 511 so 10-bit signed never overflows.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, ball_pos});
    next_pos = target;
    if (diff > STEP_S)
      next_pos = ball_pos + STEP;
    else if (diff < -STEP_S)
      next_pos = ball_pos - STEP;
  end

  always_comb begin
    gap_hi  = {1'b0, gap_pos_in} + SLACK;
    collide = pipe_at_ball_in &&
              (({1'b0, next_pos} < {1'b0, gap_pos_in}) || ({1'b0, next_pos} > gap_hi));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      ball_pos   <= CENTER;
      target     <= CENTER;
      score      <= 8'd0;
      lives      <= LIVES0;
      hit        <= 1'b0;
      freeze_cnt <= 8'd0;
      pass_flag  <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start_in) begin
            state     <= PLAYING;
            score     <= 8'd0;
            lives     <= LIVES0;
            ball_pos  <= CENTER;
            target    <= CENTER;
            pass_flag <= 1'b0;
          end
        end
        PLAYING: begin
          if (freq_valid_in)
            target <= freq_in[10:2];
          if (frame_in) begin
            ball_pos <= next_pos;
            if (collide) begin
              hit       <= 1'b1;
              lives     <= lives - 2'd1;
              pass_flag <= 1'b0;
              if (lives == 2'd1) begin
                state <= GAME_OVER;
              end else begin
                state      <= HIT;
                freeze_cnt <= FREEZE0;
              end
            end else if (pipe_at_ball_in) begin
              pass_flag <= 1'b1;
            end else if (pass_flag) begin
              score     <= score_inc(score);
              pass_flag <= 1'b0;
            end
          end
        end
        HIT: begin
          if (freq_valid_in)
            target <= freq_in[10:2];
          if (frame_in) begin
            freeze_cnt <= freeze_cnt - 8'd1;
            if (freeze_cnt <= 8'd1)
              state <= PLAYING;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ball_pos_out = ball_pos;
  assign state_out    = state;
  assign score_out    = score;
  assign lives_out    = lives;
  assign hit_out      = hit;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Directed bench for ball_game_ctrl: a vector table for motion plus hand sequences for
// scoring, collisions, freeze, game-over, boundaries, async reset and score saturation.
module tb_ball_game_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic        frame_in;
  logic        freq_valid_in;
  logic [15:0] freq_in;
  logic [8:0]  gap_pos_in;
  logic        pipe_at_ball_in;
  logic [8:0]  ball_pos_out;
  logic [1:0]  state_out;
  logic [7:0]  score_out;
  logic [1:0]  lives_out;
  logic        hit_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          start;
    bit          frame;
    bit          fv;
    logic [15:0] freq;
    bit          pipe;
    logic [8:0]  ball;
    logic [1:0]  state;
    logic [7:0]  score;
    logic [1:0]  lives;
    bit          hit;
  } vec_t;

  vec_t vecs[12];

  ball_game_ctrl dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .frame_in        (frame_in),
    .freq_valid_in   (freq_valid_in),
    .freq_in         (freq_in),
    .gap_pos_in      (gap_pos_in),
    .pipe_at_ball_in (pipe_at_ball_in),
    .ball_pos_out    (ball_pos_out),
    .state_out       (state_out),
    .score_out       (score_out),
    .lives_out       (lives_out),
    .hit_out         (hit_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic [8:0] ball, input logic [1:0] st,
                           input logic [7:0] sc, input logic [1:0] lv, input bit ht);
    check_output({name, ".ball"},  16'(ball_pos_out), 16'(ball));
    check_output({name, ".state"}, 16'(state_out),    16'(st));
    check_output({name, ".score"}, 16'(score_out),    16'(sc));
    check_output({name, ".lives"}, 16'(lives_out),    16'(lv));
    check_output({name, ".hit"},   16'(hit_out),      16'(ht));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply_stimulus(input bit st, input bit fr, input bit fv, input logic [15:0] fq, input bit pp);
    @(negedge clk_in);
    start_in        = st;
    frame_in        = fr;
    freq_valid_in   = fv;
    freq_in         = fq;
    pipe_at_ball_in = pp;
    @(posedge clk_in);
    #1;
    start_in      = 1'b0;
    frame_in      = 1'b0;
    freq_valid_in = 1'b0;
  endtask

  task automatic frame(input bit pp);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'd0, pp);
  endtask

  task automatic do_reset();
    rst_n_in        = 1'b0;
    start_in        = 1'b0;
    frame_in        = 1'b0;
    freq_valid_in   = 1'b0;
    freq_in         = 16'd0;
    gap_pos_in      = 9'd0;
    pipe_at_ball_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  function automatic logic [7:0] exp_score(input int n);
`ifdef SCORE_BCD_EN
    if (n >= 99) return 8'h99;
    return 8'(((n / 10) << 4) | (n % 10));
`else
    if (n >= 255) return 8'hFF;
    return 8'(n);
`endif
  endfunction

  initial begin
    vecs[0]  = '{0, 1, 1, 16'd1600, 0, 9'd256, 2'd0, 8'd0, 2'd3, 1'b0};
    vecs[1]  = '{1, 0, 0, 16'd0,    0, 9'd256, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[2]  = '{0, 1, 0, 16'd0,    0, 9'd256, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[3]  = '{0, 0, 1, 16'd1600, 0, 9'd256, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[4]  = '{0, 1, 1, 16'd800,  0, 9'd264, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[5]  = '{0, 1, 0, 16'd0,    0, 9'd256, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[6]  = '{0, 0, 1, 16'd1040, 0, 9'd256, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[7]  = '{0, 1, 0, 16'd0,    0, 9'd260, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[8]  = '{0, 0, 1, 16'd1600, 0, 9'd260, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[9]  = '{1, 1, 0, 16'd0,    0, 9'd268, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[10] = '{0, 1, 1, 16'd1000, 0, 9'd276, 2'd1, 8'd0, 2'd3, 1'b0};
    vecs[11] = '{0, 1, 0, 16'd0,    0, 9'd268, 2'd1, 8'd0, 2'd3, 1'b0};

    do_reset();
    #1;
    check_all("reset", 9'd256, 2'd0, 8'd0, 2'd3, 1'b0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].start, vecs[i].frame, vecs[i].fv, vecs[i].freq, vecs[i].pipe);
      check_all($sformatf("vec%0d", i), vecs[i].ball, vecs[i].state, vecs[i].score,
                vecs[i].lives, vecs[i].hit);
    end

    // Climb from centre toward target 400 in 8-pixel steps.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'd1600, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      frame(1'b0);
      check_output($sformatf("climb%0d.ball", k), 16'(ball_pos_out),
                   16'((256 + 8 * k > 400) ? 400 : 256 + 8 * k));
      check_output($sformatf("climb%0d.state", k), 16'(state_out), 16'd1);
    end

    // Clean pass through a pipe at ball 200, gap 150.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'd800, 1'b0);
    repeat (7) frame(1'b0);
    check_output("down.ball", 16'(ball_pos_out), 16'd200);
    gap_pos_in = 9'd150;
    for (int k = 0; k < 5; k++) begin
      frame(1'b1);
      check_all($sformatf("pass%0d", k), 9'd200, 2'd1, 8'd0, 2'd3, 1'b0);
    end
    frame(1'b0);
    check_all("pass.score", 9'd200, 2'd1, 8'd1, 2'd3, 1'b0);

    // Collision at 300, freeze for 60 frames, target latched during freeze.
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'd1200, 1'b0);
    repeat (13) frame(1'b0);
    check_output("to300.ball", 16'(ball_pos_out), 16'd300);
    frame(1'b1);
    check_all("hit1", 9'd300, 2'd2, 8'd1, 2'd2, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'd1600, 1'b1);
    check_all("hit1.after", 9'd300, 2'd2, 8'd1, 2'd2, 1'b0);
    for (int k = 1; k < 60; k++) begin
      frame(1'b1);
      check_output($sformatf("freeze%0d.state", k), 16'(state_out), 16'd2);
      check_output($sformatf("freeze%0d.ball", k), 16'(ball_pos_out), 16'd300);
    end
    frame(1'b1);
    check_all("freeze.end", 9'd300, 2'd1, 8'd1, 2'd2, 1'b0);
    frame(1'b0);
    check_all("resume", 9'd308, 2'd1, 8'd1, 2'd2, 1'b0);

    // Remaining lives lost, game over freezes everything, restart.
    frame(1'b1);
    check_all("hit2", 9'd316, 2'd2, 8'd1, 2'd1, 1'b1);
    repeat (60) frame(1'b0);
    check_output("hit2.recover", 16'(state_out), 16'd1);
    frame(1'b1);
    check_all("hit3", 9'd324, 2'd3, 8'd1, 2'd0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
    frame(1'b1);
    frame(1'b0);
    check_all("gameover", 9'd324, 2'd3, 8'd1, 2'd0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    check_all("restart", 9'd256, 2'd1, 8'd0, 2'd3, 1'b0);
    frame(1'b0);
    check_output("restart.ball", 16'(ball_pos_out), 16'd256);

    // Top boundary: target 511, gap 500 must not wrap.
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      frame(1'b0);
      check_output($sformatf("top%0d.ball", k), 16'(ball_pos_out),
                   16'((256 + 8 * k > 511) ? 511 : 256 + 8 * k));
    end
    gap_pos_in = 9'd500;
    frame(1'b1);
    check_all("gap500", 9'd511, 2'd1, 8'd0, 2'd3, 1'b0);
    frame(1'b0);
    check_output("gap500.score", 16'(score_out), 16'd1);

    // Asynchronous reset while frozen in HIT.
    gap_pos_in = 9'd0;
    frame(1'b1);
    check_all("hit4", 9'd511, 2'd2, 8'd1, 2'd2, 1'b1);
    #2 rst_n_in = 1'b0;
    #1;
    check_all("async_rst", 9'd256, 2'd0, 8'd0, 2'd3, 1'b0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Score saturation over 300 passes.
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    gap_pos_in = 9'd200;
    for (int n = 1; n <= 300; n++) begin
      frame(1'b1);
      frame(1'b0);
      check_output($sformatf("sat%0d.score", n), 16'(score_out), 16'(exp_score(n)));
    end
    check_output("sat.lives", 16'(lives_out), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
